// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolves a Mini SRC conditional branch (brzr/brnz/brpl/brmi) for the
// control sequencer. On start it latches the instruction fields and PC+1.
// It then spends one cycle with R[Ra] on the bus and condition evaluation
// enabled. Next it samples the CON flag and strobes the PC with either the
// branch target or the fall-through address. Finally it pulses done.
//
// Ports:
//   Clock     - system clock, rising-edge active
//   Clear     - synchronous active-high reset
//   start     - one-cycle resolve request (ignored while busy)
//   IR        - instruction word {opcode[31:27], Ra[26:23], C2[22:19], C[18:0]}
//   PC_plus1  - address of the instruction after the branch
//   CON       - condition flag from the condition flip-flop
//   Ra_sel    - latched Ra field, register select for the bus read
//   Rout      - gate R[Ra] onto the bus (EVAL only)
//   CONin     - enable condition evaluation (EVAL only)
//   C2_out    - latched C2 field, condition selector
//   PC_next   - value to load into PC
//   PCin      - one-cycle PC load strobe (DECIDE only)
//   busy      - high in EVAL, DECIDE and DONE
//   done      - one-cycle completion pulse
//   taken     - branch decision, held until the next accepted start
//   bad_op    - opcode of the last accepted request was not a branch
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int         DATA_WIDTH   = 32,
  parameter int         OFFSET_WIDTH = 19,
  parameter logic [4:0] BR_OPCODE    = 5'b10010
) (
  input  logic                  Clock,
  input  logic                  Clear,
  input  logic                  start,
  input  logic [31:0]           IR,
  input  logic [DATA_WIDTH-1:0] PC_plus1,
  input  logic                  CON,
  output logic [3:0]            Ra_sel,
  output logic                  Rout,
  output logic                  CONin,
  output logic [3:0]            C2_out,
  output logic [DATA_WIDTH-1:0] PC_next,
  output logic                  PCin,
  output logic                  busy,
  output logic                  done,
  output logic                  taken,
  output logic                  bad_op
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    DECIDE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Sign-extend the branch displacement to the PC width.
  function automatic logic [DATA_WIDTH-1:0] sext_offset(input logic [OFFSET_WIDTH-1:0] off);
    sext_offset = {{(DATA_WIDTH-OFFSET_WIDTH){off[OFFSET_WIDTH-1]}}, off};
  endfunction

  state_t                  state_r;
  logic [DATA_WIDTH-1:0]   fall_r;      // latched PC_plus1
  logic [DATA_WIDTH-1:0]   target_r;    // latched PC_plus1 + sext(C)
  logic [DATA_WIDTH-1:0]   pc_next_r;   // PC_next held outside DECIDE
  logic                    taken_r;     // decision held outside DECIDE
  logic [DATA_WIDTH-1:0]   target_s;
  logic                    opcode_ok_s;

  // Target address and opcode match from the live IR, used only when a start is accepted.
  // The target sum is computed up front so DECIDE reduces to a 2:1 mux on CON.
  always_comb begin
    target_s    = PC_plus1 + sext_offset(IR[OFFSET_WIDTH-1:0]);
    opcode_ok_s = (IR[31:27] == BR_OPCODE);
  end

  // PC_next and taken must be valid in the same cycle as PCin. CON only settles
  // at the edge that ends EVAL, so DECIDE forwards the live CON decision.
  // Every other state shows the held copy.
  always_comb begin
    if (state_r == DECIDE) begin
      PC_next = CON ? target_r : fall_r;
      taken   = CON;
    end else begin
      PC_next = pc_next_r;
      taken   = taken_r;
    end
  end

  // Sequencer FSM with registered strobes and latched instruction fields.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_r   <= IDLE;
      Ra_sel    <= 4'd0;
      C2_out    <= 4'd0;
      Rout      <= 1'b0;
      CONin     <= 1'b0;
      PCin      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bad_op    <= 1'b0;
      taken_r   <= 1'b0;
      fall_r    <= '0;
      target_r  <= '0;
      pc_next_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            Ra_sel   <= IR[26:23];
            C2_out   <= IR[22:19];
            fall_r   <= PC_plus1;
            target_r <= target_s;
            taken_r  <= 1'b0;
            busy     <= 1'b1;
            if (opcode_ok_s) begin
              state_r <= EVAL;
              Rout    <= 1'b1;
              CONin   <= 1'b1;
              bad_op  <= 1'b0;
            end else begin
              // Skip straight to completion; PC_next keeps its prior value.
              state_r <= DONE;
              done    <= 1'b1;
              bad_op  <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        EVAL: begin
          state_r <= DECIDE;
          Rout    <= 1'b0;
          CONin   <= 1'b0;
          PCin    <= 1'b1;
        end
        DECIDE: begin
          state_r   <= DONE;
          taken_r   <= CON;
          pc_next_r <= CON ? target_r : fall_r;
          PCin      <= 1'b0;
          done      <= 1'b1;
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          Rout    <= 1'b0;
          CONin   <= 1'b0;
          PCin    <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Directed testbench for branch_resolve_unit. Inputs are driven on the
// falling edge, and outputs are sampled on the falling edge of each cycle.
// The control strobes are compared as one vector
// {Rout, CONin, PCin, done, busy}.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

  logic        Clock;
  logic        Clear;
  logic        start;
  logic [31:0] IR;
  logic [31:0] PC_plus1;
  logic        CON;
  logic [3:0]  Ra_sel;
  logic        Rout;
  logic        CONin;
  logic [3:0]  C2_out;
  logic [31:0] PC_next;
  logic        PCin;
  logic        busy;
  logic        done;
  logic        taken;
  logic        bad_op;

  int tests_run;
  int tests_failed;

  branch_resolve_unit #(
    .DATA_WIDTH  (32),
    .OFFSET_WIDTH(19),
    .BR_OPCODE   (5'b10010)
  ) dut (
    .Clock   (Clock),
    .Clear   (Clear),
    .start   (start),
    .IR      (IR),
    .PC_plus1(PC_plus1),
    .CON     (CON),
    .Ra_sel  (Ra_sel),
    .Rout    (Rout),
    .CONin   (CONin),
    .C2_out  (C2_out),
    .PC_next (PC_next),
    .PCin    (PCin),
    .busy    (busy),
    .done    (done),
    .taken   (taken),
    .bad_op  (bad_op)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] c2, input logic [18:0] c);
    mk_ir = {op, ra, c2, c};
  endfunction

  // Present a request at the falling edge, hold start across one rising edge,
  // then return at the next falling edge (first cycle after acceptance).
  task automatic issue(input logic [31:0] ir, input logic [31:0] pc);
    @(negedge Clock);
    IR       = ir;
    PC_plus1 = pc;
    start    = 1'b1;
    @(posedge Clock);
    #1 start = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_reset;
    Clear = 1'b1;
    start = 1'b1;
    IR    = mk_ir(5'b10010, 4'd5, 4'd2, 19'd9);
    repeat (2) @(negedge Clock);
    tests_run++;
    if ({Ra_sel, C2_out, PC_next, Rout, CONin, PCin, busy, done, taken, bad_op} !== 47'd0) begin
      $display("FAIL reset_outputs: got Ra_sel=%0h C2=%0h PC_next=%h ctl=%b%b%b%b%b taken=%b bad_op=%b, want all 0",
               Ra_sel, C2_out, PC_next, Rout, CONin, PCin, busy, done, taken, bad_op);
      tests_failed++;
    end
    start = 1'b0;
    Clear = 1'b0;
    @(negedge Clock);
  endtask

  // One valid branch from start to return to IDLE. Inputs are disturbed
  // outside their sampling cycles to show that they are latched or ignored.
  task automatic test_branch(input string name, input logic [31:0] ir, input logic [31:0] pc,
                             input logic con, input logic [31:0] exp_pc);
    issue(ir, pc);
    // EVAL
    tests_run++;
    if ({Rout, CONin, PCin, done, busy} !== 5'b11001 || Ra_sel !== ir[26:23] || C2_out !== ir[22:19]) begin
      $display("FAIL %s_eval: got ctl=%b Ra=%0h C2=%0h, want ctl=11001 Ra=%0h C2=%0h",
               name, {Rout, CONin, PCin, done, busy}, Ra_sel, C2_out, ir[26:23], ir[22:19]);
      tests_failed++;
    end
    CON      = con;
    IR       = 32'hFFFF_FFFF;
    PC_plus1 = 32'hDEAD_0000;
    @(negedge Clock);
    // DECIDE
    tests_run++;
    if ({Rout, CONin, PCin, done, busy} !== 5'b00101 || PC_next !== exp_pc || taken !== con) begin
      $display("FAIL %s_decide: got ctl=%b PC_next=%h taken=%b, want ctl=00101 PC_next=%h taken=%b",
               name, {Rout, CONin, PCin, done, busy}, PC_next, taken, exp_pc, con);
      tests_failed++;
    end
    @(negedge Clock);
    CON = ~con;
    #1;
    // DONE (CON now flipped; decision must hold)
    tests_run++;
    if ({Rout, CONin, PCin, done, busy} !== 5'b00011 || PC_next !== exp_pc || taken !== con || bad_op !== 1'b0) begin
      $display("FAIL %s_done: got ctl=%b PC_next=%h taken=%b bad_op=%b, want ctl=00011 PC_next=%h taken=%b bad_op=0",
               name, {Rout, CONin, PCin, done, busy}, PC_next, taken, bad_op, exp_pc, con);
      tests_failed++;
    end
    @(negedge Clock);
    // back in IDLE
    tests_run++;
    if ({Rout, CONin, PCin, done, busy} !== 5'b00000 || PC_next !== exp_pc || taken !== con) begin
      $display("FAIL %s_idle: got ctl=%b PC_next=%h taken=%b, want ctl=00000 PC_next=%h taken=%b",
               name, {Rout, CONin, PCin, done, busy}, PC_next, taken, exp_pc, con);
      tests_failed++;
    end
  endtask

  // Bad opcode: completion the cycle after start, no bus/PC strobes, PC_next kept.
  task automatic test_bad_op(input logic [31:0] prev_pc);
    issue(mk_ir(5'b00000, 4'd3, 4'd0, 19'd5), 32'h0000_0040);
    tests_run++;
    if ({Rout, CONin, PCin, done, busy} !== 5'b00011 || bad_op !== 1'b1 || PC_next !== prev_pc || taken !== 1'b0) begin
      $display("FAIL bad_op_done: got ctl=%b bad_op=%b PC_next=%h taken=%b, want ctl=00011 bad_op=1 PC_next=%h taken=0",
               {Rout, CONin, PCin, done, busy}, bad_op, PC_next, taken, prev_pc);
      tests_failed++;
    end
    @(negedge Clock);
    tests_run++;
    if ({Rout, CONin, PCin, done, busy} !== 5'b00000 || bad_op !== 1'b1 || PC_next !== prev_pc) begin
      $display("FAIL bad_op_idle: got ctl=%b bad_op=%b PC_next=%h, want ctl=00000 bad_op=1 PC_next=%h",
               {Rout, CONin, PCin, done, busy}, bad_op, PC_next, prev_pc);
      tests_failed++;
    end
  endtask

  // A second start held high through EVAL, DECIDE and DONE must be dropped.
  task automatic test_start_busy;
    int pcin_cnt;
    int done_cnt;
    pcin_cnt = 0;
    done_cnt = 0;
    issue(mk_ir(5'b10010, 4'd3, 4'd1, 19'd8), 32'h0000_0100);
    start = 1'b1;
    IR    = mk_ir(5'b10010, 4'd7, 4'd2, 19'd100);
    CON   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        tests_run++;
        if (PC_next !== 32'h0000_0108 || taken !== 1'b1) begin
          $display("FAIL busy_decide: got PC_next=%h taken=%b, want PC_next=00000108 taken=1", PC_next, taken);
          tests_failed++;
        end
      end
      @(negedge Clock);
      pcin_cnt += int'(PCin);
      done_cnt += int'(done);
    end
    // First IDLE cycle after DONE: the start seen in DONE must not have been taken.
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || Ra_sel !== 4'd3 || C2_out !== 4'd1 || PC_next !== 32'h0000_0108) begin
      $display("FAIL busy_dropped: got busy=%b Ra=%0h C2=%0h PC_next=%h, want busy=0 Ra=3 C2=1 PC_next=00000108",
               busy, Ra_sel, C2_out, PC_next);
      tests_failed++;
    end
    repeat (2) begin
      @(negedge Clock);
      pcin_cnt += int'(PCin);
      done_cnt += int'(done);
    end
    tests_run++;
    if (pcin_cnt != 1 || done_cnt != 1) begin
      $display("FAIL busy_pulses: got PCin=%0d done=%0d pulses, want 1 and 1", pcin_cnt, done_cnt);
      tests_failed++;
    end
  endtask

  // Clear during EVAL aborts the request; a following request works normally.
  task automatic test_clear_mid;
    int strobe_cnt;
    strobe_cnt = 0;
    issue(mk_ir(5'b10010, 4'd9, 4'd3, 19'd5), 32'h0000_0200);
    Clear = 1'b1;
    CON   = 1'b1;
    @(negedge Clock);
    Clear = 1'b0;
    tests_run++;
    if ({Ra_sel, C2_out, PC_next, Rout, CONin, PCin, busy, done, taken, bad_op} !== 47'd0) begin
      $display("FAIL clear_mid_outputs: got Ra=%0h C2=%0h PC_next=%h ctl=%b taken=%b bad_op=%b, want all 0",
               Ra_sel, C2_out, PC_next, {Rout, CONin, PCin, done, busy}, taken, bad_op);
      tests_failed++;
    end
    repeat (3) begin
      @(negedge Clock);
      strobe_cnt += int'(PCin) + int'(done) + int'(busy);
    end
    tests_run++;
    if (strobe_cnt != 0) begin
      $display("FAIL clear_mid_quiet: got %0d strobe cycles after Clear, want 0", strobe_cnt);
      tests_failed++;
    end
    test_branch("after_clear", mk_ir(5'b10010, 4'd2, 4'd4, 19'd16), 32'h0000_0300, 1'b1, 32'h0000_0310);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    Clear        = 1'b0;
    start        = 1'b0;
    IR           = 32'd0;
    PC_plus1     = 32'd0;
    CON          = 1'b0;

    test_reset();
    test_branch("taken",     mk_ir(5'b10010, 4'd3, 4'd0, 19'd5),      32'h0000_0020, 1'b1, 32'h0000_0025);
    test_branch("not_taken", mk_ir(5'b10010, 4'd3, 4'd0, 19'd5),      32'h0000_0020, 1'b0, 32'h0000_0020);
    test_branch("neg_off",   mk_ir(5'b10010, 4'd6, 4'd2, 19'h7FFFC),  32'h0000_0010, 1'b1, 32'h0000_000C);
    test_branch("wrap",      mk_ir(5'b10010, 4'd1, 4'd3, 19'h7FFFC),  32'h0000_0002, 1'b1, 32'hFFFF_FFFE);
    test_bad_op(32'hFFFF_FFFE);
    test_start_busy();
    test_clear_mid();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Control-side consumer of the condition flip-flop for Mini SRC conditional branches (brzr/brnz/brpl/brmi).
- On start, it latches the branch instruction and PC, and places R[Ra] on the bus with condition evaluation enabled.
- It then samples the resulting CON flag and loads the PC with either the branch target or the fall-through address.
- It sits between the control sequencer and the datapath: it drives CONin/C2 into the condition flip-flop and the PC load strobe, and reports completion back to the sequencer.

Parameters:
- DATA_WIDTH, 32, width of PC and bus values.
- OFFSET_WIDTH, 19, width of the signed branch displacement field IR[18:0].
- BR_OPCODE, 5'b10010, opcode value IR[31:27] identifying a conditional branch.

Ports:
- Clock  input  1  system clock; all state changes on rising edge.
- Clear  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to resolve the instruction on IR; ignored while busy=1.
- IR  input  32  instruction word; fields: opcode[31:27], Ra[26:23], C2[22:19], C[18:0].
- PC_plus1  input  DATA_WIDTH  address of the instruction after the branch.
- CON  input  1  condition flag from the condition flip-flop.
- Ra_sel  output  4  register select for the bus read; equals latched IR[26:23].
- Rout  output  1  enables R[Ra] onto the bus.
- CONin  output  1  enables condition evaluation in the condition flip-flop.
- C2_out  output  4  condition selector; equals latched IR[22:19].
- PC_next  output  DATA_WIDTH  value to load into PC.
- PCin  output  1  PC load strobe, one cycle.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle completion pulse.
- taken  output  1  branch decision; held until the next accepted start.
- bad_op  output  1  latched opcode mismatch flag for the last request.

Behaviour:
- Reset (Clear=1 at a rising edge):
  - State returns to IDLE.
  - All outputs go to 0, including PC_next, taken, bad_op, Ra_sel and C2_out.
  - Clear overrides start and any in-flight operation; no PCin is issued after a mid-operation Clear.
- FSM states are IDLE, EVAL, DECIDE, DONE.
- IDLE:
  - start=1 latches IR, PC_plus1 and opcode-match, and clears taken and bad_op.
  - If the opcode matches, go to EVAL; otherwise set bad_op=1 and go to DONE.
- EVAL (exactly 1 cycle):
  - Rout=1 and CONin=1; Ra_sel and C2_out hold the latched fields.
  - The condition flip-flop updates CON at the edge ending this cycle.
  - Go to DECIDE.
- DECIDE (1 cycle):
  - Sample CON into taken.
  - PC_next = latched PC_plus1 + sign_extend(C) if CON=1, else latched PC_plus1.
  - Addition is modulo 2^DATA_WIDTH; wrap-around is allowed and unflagged.
  - PCin=1 for this cycle only. Go to DONE.
- DONE:
  - done=1 for one cycle; PCin=0; return to IDLE.
  - For the bad_op path, PCin is never asserted and PC_next keeps its prior value.
- busy=1 in EVAL, DECIDE and DONE; 0 in IDLE.
- Latency:
  - Valid branch: start accepted at edge N; EVAL in cycle N+1; PCin in cycle N+2; done in cycle N+3.
  - Bad opcode: done in cycle N+1.
- start while busy=1 is dropped (no queueing). start in the DONE cycle is also dropped; the next start is accepted in IDLE.
- IR, PC_plus1 and CON changes outside their sampling cycles have no effect.
- Rout, CONin and PCin are mutually scheduled: never high in IDLE or DONE.

Test Plan:
- Taken branch, positive offset: IR={10010,Ra=3,C2=0000,C=19'd5}, PC_plus1=0x20, CON=1 in DECIDE -> CONin/Rout high 1 cycle, then PCin=1 with PC_next=0x25, taken=1, done 3 cycles after start.
- Not taken: same IR, CON=0 -> PC_next=0x20, taken=0, PCin still pulsed once.
- Negative offset: C=19'h7FFFC (-4), PC_plus1=0x10, CON=1 -> PC_next=0x0C. Also PC_plus1=0x2 with C=-4 -> PC_next=0xFFFFFFFE (wrap).
- Bad opcode: IR[31:27]=5'b00000, start -> bad_op=1, done next cycle; CONin, Rout and PCin never asserted; PC_next unchanged.
- Start while busy: second start in EVAL with a different IR -> ignored; exactly one PCin/done, and results reflect the first IR.
- Clear mid-op: Clear asserted during EVAL -> next cycle IDLE, all outputs 0, no PCin or done; a subsequent start is processed normally.
